cart_mem_arbiter: RTL



---
 rtl/cart_mem_pkg.sv | 23 ++
 rtl/cart_mem_req_latch.sv | 75 +++++++
 rtl/cart_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cart_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cart_mem_pkg: shared types for the cartridge memory arbiter.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cart_mem_pkg;

  localparam int MEM_AW = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_ROM    = 2'd0,
    GNT_SRAM   = 2'd1,
    GNT_LOADER = 2'd2
  } arb_gnt_t;

endpackage
`default_nettype wire

// File: rtl/cart_mem_req_latch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cart_mem_req_latch: turns a level cart strobe into one pending     |
// | request with captured address/data/direction. Rev 1.0              |
// +--------------------------------------------------------------------+
module cart_mem_req_latch
  import cart_mem_pkg::*;
#(
  parameter logic [MEM_AW-1:0] ADDR_OFFSET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rden,
  input  logic              wren,
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        data,
  input  logic              clr,
  input  logic              busy,
  output logic              pend,
  output logic [MEM_AW-1:0] req_addr,
  output logic [7:0]        req_data,
  output logic              req_we
);

  logic              strobe;
  logic              capture;
  logic              strobe_prev_q, strobe_prev_d;
  logic              pend_q, pend_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  assign strobe  = rden | wren;
  // Edges arriving while this channel is queued or in flight are dropped.
  assign capture = strobe & ~strobe_prev_q & ~pend_q & ~busy;

  always_comb begin
    strobe_prev_d = strobe;
    pend_d        = pend_q;
    addr_d        = addr_q;
    data_d        = data_q;
    we_d          = we_q;
    if (capture) begin
      pend_d = 1'b1;
      addr_d = addr + ADDR_OFFSET;
      data_d = data;
      we_d   = wren;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_prev_q <= 1'b0;
      pend_q        <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
    end else begin
      strobe_prev_q <= strobe_prev_d;
      pend_q        <= pend_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_q          <= we_d;
    end
  end

  assign pend     = pend_q;
  assign req_addr = addr_q;
  assign req_data = data_q;
  assign req_we   = we_q;

endmodule
`default_nettype wire

// File: rtl/cart_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cart_mem_arbiter: fixed-priority sharing of one memory port among  |
// | two cart channels and the loader. Rev 1.0                          |
// +--------------------------------------------------------------------+
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter logic [MEM_AW-1:0] SRAM_BASE = 25'h1F0_0000,
  parameter bit                WAIT_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MEM_AW-1:0] cart_addr [2],
  input  logic [7:0]        cart_data [2],
  input  logic [1:0]        cart_rden,
  input  logic [1:0]        cart_wren,
  output logic [7:0]        cart_q [2],
  output logic              cart_wait,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_we,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [7:0]        ld_q,
  output logic              ld_qvalid,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_q
);

  logic [1:0]        pend;
  logic [1:0]        busy;
  logic [1:0]        clr;
  logic [MEM_AW-1:0] req_addr [2];
  logic [7:0]        req_data [2];
  logic [1:0]        req_we;

  arb_state_t        state_q, state_d;
  arb_gnt_t          gnt_q, gnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [7:0]        cart_q_q [2];
  logic [7:0]        cart_q_d [2];
  logic [7:0]        ld_q_q, ld_q_d;
  logic              ld_qvalid_q, ld_qvalid_d;

  assign busy[0] = (state_q != IDLE) && (gnt_q == GNT_ROM);
  assign busy[1] = (state_q != IDLE) && (gnt_q == GNT_SRAM);

  generate
    for (genvar c = 0; c < 2; c++) begin : g_chan
      cart_mem_req_latch #(
        .ADDR_OFFSET((c == 1) ? SRAM_BASE : {MEM_AW{1'b0}})
      ) u_latch (
        .clk      (clk),
        .reset    (reset),
        .rden     (cart_rden[c]),
        .wren     (cart_wren[c]),
        .addr     (cart_addr[c]),
        .data     (cart_data[c]),
        .clr      (clr[c]),
        .busy     (busy[c]),
        .pend     (pend[c]),
        .req_addr (req_addr[c]),
        .req_data (req_data[c]),
        .req_we   (req_we[c])
      );
    end
  endgenerate

  assign ld_ready = (state_q == IDLE) && (pend == 2'b00);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cart_q_d    = cart_q_q;
    ld_q_d      = ld_q_q;
    ld_qvalid_d = 1'b0;
    clr         = 2'b00;
    case (state_q)
      IDLE: begin
        if (pend[0]) begin
          gnt_d      = GNT_ROM;
          clr[0]     = 1'b1;
          mem_addr_d = req_addr[0];
          mem_din_d  = req_data[0];
          mem_we_d   = req_we[0];
          mem_req_d  = 1'b1;
          state_d    = ISSUE;
        end else if (pend[1]) begin
          gnt_d      = GNT_SRAM;
          clr[1]     = 1'b1;
          mem_addr_d = req_addr[1];
          mem_din_d  = req_data[1];
          mem_we_d   = req_we[1];
          mem_req_d  = 1'b1;
          state_d    = ISSUE;
        end else if (ld_valid && ld_ready) begin
          gnt_d      = GNT_LOADER;
          mem_addr_d = ld_addr;
          mem_din_d  = ld_data;
          mem_we_d   = ld_we;
          mem_req_d  = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (gnt_q == GNT_LOADER) begin
            ld_q_d      = mem_q;
            ld_qvalid_d = 1'b1;
          end else begin
            cart_q_d[gnt_q[0]] = mem_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_ROM;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cart_q_q[0] <= 8'hFF;
      cart_q_q[1] <= 8'hFF;
      ld_q_q      <= 8'h00;
      ld_qvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cart_q_q[0] <= cart_q_d[0];
      cart_q_q[1] <= cart_q_d[1];
      ld_q_q      <= ld_q_d;
      ld_qvalid_q <= ld_qvalid_d;
    end
  end

  assign cart_wait = WAIT_EN & ((|pend) | ((state_q != IDLE) && (gnt_q != GNT_LOADER)));
  assign cart_q[0] = cart_q_q[0];
  assign cart_q[1] = cart_q_q[1];
  assign ld_q      = ld_q_q;
  assign ld_qvalid = ld_qvalid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign mem_req   = mem_req_q;

endmodule
`default_nettype wire
